// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: shared tick prescaler plus per-channel
// off/on/blink/pulse modes, reconfigurable at run time through a write port.
module led_pattern_gen #(
  parameter int unsigned NUM_LEDS     = 2,
  parameter int unsigned PRESCALE     = 4_000_000,
  parameter int unsigned RATE_W       = 4,
  parameter int unsigned DEFAULT_RATE = 1,
  localparam int unsigned CH_W        = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [1:0]          wr_mode,
  input  logic [RATE_W-1:0]   wr_rate,
  input  logic                sync,
  output logic                tick,
  output logic [NUM_LEDS-1:0] led
);

  localparam int unsigned PCNT_W = $clog2(PRESCALE);

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_ON    = 2'b01;
  localparam logic [1:0] MODE_BLINK = 2'b10;
  localparam logic [1:0] MODE_PULSE = 2'b11;

  logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
  logic [1:0]          mode_q  [NUM_LEDS];
  logic [1:0]          mode_d  [NUM_LEDS];
  logic [RATE_W-1:0]   rate_q  [NUM_LEDS];
  logic [RATE_W-1:0]   rate_d  [NUM_LEDS];
  logic [RATE_W-1:0]   phase_q [NUM_LEDS];
  logic [RATE_W-1:0]   phase_d [NUM_LEDS];
  logic [NUM_LEDS-1:0] bstate_q, bstate_d;
  logic [NUM_LEDS-1:0] pflag_q, pflag_d;
  logic [NUM_LEDS-1:0] led_d;

  // Tick is decoded straight from the prescaler count.
  assign tick = (pcnt_q == PCNT_W'(PRESCALE - 1));

  // Next-state for prescaler and every channel; led follows the next state so
  // a tick or write in cycle n is visible on the pins in cycle n+1.
  always_comb begin
    pcnt_d = (sync || tick) ? '0 : pcnt_q + PCNT_W'(1);
    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
      mode_d[i]   = mode_q[i];
      rate_d[i]   = rate_q[i];
      phase_d[i]  = phase_q[i];
      bstate_d[i] = bstate_q[i];
      pflag_d[i]  = pflag_q[i];
      led_d[i]    = 1'b0;
      if (wr_en && (32'(wr_ch) == i)) begin
        // Write also covers a coincident sync: both clear the same state.
        mode_d[i]   = wr_mode;
        rate_d[i]   = wr_rate;
        phase_d[i]  = '0;
        bstate_d[i] = 1'(i % 2);
        pflag_d[i]  = 1'b0;
      end else if (sync) begin
        phase_d[i]  = '0;
        bstate_d[i] = 1'(i % 2);
        pflag_d[i]  = 1'b0;
      end else if (tick) begin
        case (mode_q[i])
          MODE_BLINK: begin
            if (phase_q[i] == rate_q[i]) begin
              phase_d[i]  = '0;
              bstate_d[i] = ~bstate_q[i];
            end else begin
              phase_d[i]  = phase_q[i] + RATE_W'(1);
            end
          end
          MODE_PULSE: begin
            if (phase_q[i] == rate_q[i]) begin
              phase_d[i] = '0;
              pflag_d[i] = 1'b1;
            end else begin
              phase_d[i] = phase_q[i] + RATE_W'(1);
              pflag_d[i] = 1'b0;
            end
          end
          default: ;
        endcase
      end
      case (mode_d[i])
        MODE_OFF:   led_d[i] = 1'b0;
        MODE_ON:    led_d[i] = 1'b1;
        MODE_BLINK: led_d[i] = bstate_d[i];
        default:    led_d[i] = pflag_d[i];
      endcase
    end
  end

  // State registers; reset restores the alternating blink pattern.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q <= '0;
      for (int unsigned i = 0; i < NUM_LEDS; i++) begin
        mode_q[i]   <= MODE_BLINK;
        rate_q[i]   <= RATE_W'(DEFAULT_RATE);
        phase_q[i]  <= '0;
        bstate_q[i] <= 1'(i % 2);
        pflag_q[i]  <= 1'b0;
        led[i]      <= 1'(i % 2);
      end
    end else begin
      pcnt_q <= pcnt_d;
      for (int unsigned i = 0; i < NUM_LEDS; i++) begin
        mode_q[i]   <= mode_d[i];
        rate_q[i]   <= rate_d[i];
        phase_q[i]  <= phase_d[i];
        bstate_q[i] <= bstate_d[i];
        pflag_q[i]  <= pflag_d[i];
        led[i]      <= led_d[i];
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen: a 2-channel and a 3-channel instance,
// PRESCALE=4, DEFAULT_RATE=1; cycle 0 is the first cycle after rst drops.
module tb_led_pattern_gen;

  logic       clk = 1'b0;
  logic       rst;

  logic       wr_en;
  logic [0:0] wr_ch;
  logic [1:0] wr_mode;
  logic [3:0] wr_rate;
  logic       sync;
  logic       tick;
  logic [1:0] led;

  logic       wr_en3;
  logic [1:0] wr_ch3;
  logic [1:0] wr_mode3;
  logic [3:0] wr_rate3;
  logic       sync3;
  logic       tick3;
  logic [2:0] led3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  led_pattern_gen #(.NUM_LEDS(2), .PRESCALE(4), .RATE_W(4), .DEFAULT_RATE(1)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_mode(wr_mode),
    .wr_rate(wr_rate), .sync(sync), .tick(tick), .led(led)
  );

  led_pattern_gen #(.NUM_LEDS(3), .PRESCALE(4), .RATE_W(4), .DEFAULT_RATE(1)) dut3 (
    .clk(clk), .rst(rst), .wr_en(wr_en3), .wr_ch(wr_ch3), .wr_mode(wr_mode3),
    .wr_rate(wr_rate3), .sync(sync3), .tick(tick3), .led(led3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_ch = '0; wr_mode = '0; wr_rate = '0; sync = 1'b0;
    wr_en3 = 1'b0; wr_ch3 = '0; wr_mode3 = '0; wr_rate3 = '0; sync3 = 1'b0;
  endtask

  // Advance one cycle; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  // Returns positioned in cycle 0.
  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
  endtask

  // Power-up alternating pattern: 10 for 8 cycles, then 01, and so on.
  function automatic logic [1:0] def_led(input int c);
    return (((c / 8) % 2) == 1) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic def_tick(input int c);
    return (c % 4) == 3;
  endfunction

  initial begin
    logic [1:0] exp2;
    logic [2:0] exp3;
    logic       e0;

    // Reset default followed by ch0 on (cycle 20) and off (cycle 30).
    do_reset();
    for (int c = 0; c <= 40; c++) begin
      if (c == 20) begin wr_en = 1'b1; wr_ch = 1'b0; wr_mode = 2'b01; wr_rate = 4'd1; end
      if (c == 30) begin wr_en = 1'b1; wr_ch = 1'b0; wr_mode = 2'b00; wr_rate = 4'd1; end
      exp2 = def_led(c);
      if (c >= 21 && c <= 30) exp2[0] = 1'b1;
      else if (c >= 31)       exp2[0] = 1'b0;
      check($sformatf("onoff_led c%0d", c), 32'(led), 32'(exp2));
      check($sformatf("onoff_tick c%0d", c), 32'(tick), 32'(def_tick(c)));
      step();
    end

    // Pulse on ch1, rate 2, written in cycle 1.
    do_reset();
    for (int c = 0; c <= 40; c++) begin
      if (c == 1) begin wr_en = 1'b1; wr_ch = 1'b1; wr_mode = 2'b11; wr_rate = 4'd2; end
      exp2 = def_led(c);
      if (c < 2) exp2[1] = 1'b1;
      else       exp2[1] = (c >= 12) && (((c - 12) % 12) < 4);
      check($sformatf("pulse_led c%0d", c), 32'(led), 32'(exp2));
      step();
    end

    // Sync in cycle 13 realigns pattern and prescaler.
    do_reset();
    for (int c = 0; c <= 32; c++) begin
      if (c == 13) sync = 1'b1;
      if (c <= 13) begin
        check($sformatf("sync_led c%0d", c), 32'(led), 32'(def_led(c)));
        check($sformatf("sync_tick c%0d", c), 32'(tick), 32'(def_tick(c)));
      end else begin
        check($sformatf("sync_led c%0d", c), 32'(led), 32'(def_led(c - 14)));
        check($sformatf("sync_tick c%0d", c), 32'(tick), 32'(def_tick(c - 14)));
      end
      step();
    end

    // Reset coinciding with a write: write ignored, default sequence restarts.
    do_reset();
    for (int c = 0; c < 25; c++) step();
    check("rstmid_pre_led", 32'(led), 32'(def_led(25)));
    rst = 1'b1;
    wr_en = 1'b1; wr_ch = 1'b0; wr_mode = 2'b01; wr_rate = 4'd0;
    step();
    rst = 1'b0;
    for (int c = 0; c <= 20; c++) begin
      check($sformatf("rstmid_led c%0d", c), 32'(led), 32'(def_led(c)));
      check($sformatf("rstmid_tick c%0d", c), 32'(tick), 32'(def_tick(c)));
      step();
    end

    // 3-channel: write on a tick cycle, then an out-of-range write.
    do_reset();
    for (int c = 0; c <= 24; c++) begin
      if (c == 3) begin wr_en3 = 1'b1; wr_ch3 = 2'd2; wr_mode3 = 2'b10; wr_rate3 = 4'd0; end
      if (c == 5) begin wr_en3 = 1'b1; wr_ch3 = 2'd3; wr_mode3 = 2'b01; wr_rate3 = 4'd0; end
      e0 = ((c / 8) % 2) == 1;
      exp3[0] = e0;
      exp3[1] = ~e0;
      exp3[2] = (c >= 8) && ((((c - 8) / 4) % 2) == 0);
      check($sformatf("ch3_led c%0d", c), 32'(led3), 32'(exp3));
      check($sformatf("ch3_tick c%0d", c), 32'(tick3), 32'(def_tick(c)));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Multi-channel LED pattern generator that drives NUM_LEDS board LEDs from one system clock. It generalises the two-LED alternating blinker with a shared tick prescaler and independently programmed per-channel modes: off, on, blink and pulse. Channels are reconfigured at run time through a single-cycle write port. It sits between the board clock/reset and the LED pins. Its power-up pattern is the classic alternating blink, so it works with no configuration.

## Interface
- NUM_LEDS, 2: number of LED channels (1..16).
- PRESCALE, 4_000_000: clock cycles per tick (>= 2).
- RATE_W, 4: width of the per-channel rate field.
- DEFAULT_RATE, 1: reset rate of every channel (< 2^RATE_W).
- CH_W, derived = max(1, clog2(NUM_LEDS)): channel-select width.
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- wr_en  in  1  single-cycle channel-configuration strobe.
- wr_ch  in  CH_W  channel index; a write with wr_ch >= NUM_LEDS is ignored.
- wr_mode  in  2  channel mode: 00 off, 01 on, 10 blink, 11 pulse.
- wr_rate  in  RATE_W  channel rate: event period in ticks, minus one.
- sync  in  1  single-cycle strobe that realigns all channels.
- tick  out  1  high for one cycle every PRESCALE cycles.
- led  out  NUM_LEDS  LED drive, active-high, registered.

## Operation
- Prescaler:
  - pcnt counts 0..PRESCALE-1, then wraps to 0.
  - tick = (pcnt == PRESCALE-1), decoded from pcnt.
- Per-channel state:
  - mode[1:0], rate[RATE_W-1:0], phase[RATE_W-1:0], bstate (blink level), pflag (pulse level).
  - Blink initial level init(i): 0 for even i, 1 for odd i.
- Per-tick update, applied when tick is high:
  - off: led=0; phase and bstate hold.
  - on: led=1; phase and bstate hold.
  - blink: if phase==rate then phase<=0 and bstate toggles, else phase<=phase+1. led=bstate. Half-period is (rate+1) ticks.
  - pulse: if phase==rate then phase<=0 and pflag<=1, else phase<=phase+1 and pflag<=0. led=pflag. The LED is high for one tick period (PRESCALE cycles) every (rate+1) ticks. With rate=0, pflag is set on every tick.
- Write (wr_en=1, wr_ch < NUM_LEDS):
  - The addressed channel loads mode and rate.
  - phase<=0, bstate<=init(ch), pflag<=0.
  - The write takes effect at the next edge.
  - Other channels are unaffected.
- Priority, highest first: rst, then write/sync for the affected channel, then tick.
  - A tick coincident with a write is ignored for the written channel only.
- sync:
  - Sets pcnt<=0.
  - For every channel: phase<=0, bstate<=init(i), pflag<=0. mode and rate are unchanged.
  - If wr_en coincides with sync, both apply: the written channel gets the new mode/rate plus the sync clearing.
- Reset (rst=1 at an edge):
  - pcnt=0, tick=0.
  - Every channel: mode=blink, rate=DEFAULT_RATE, phase=0, bstate=init(i), pflag=0.
  - led resets to the init(i) pattern, e.g. 2'b10 for NUM_LEDS=2.
  - wr_en and sync are ignored while rst is high.
- Arithmetic: phase never exceeds rate. If rate is lowered below the current phase, no wrap glitch can occur, because every write clears phase.

## Timing
- led is a registered function of mode, bstate and pflag.
  - A tick in cycle n changes led in cycle n+1.
  - A write in cycle n changes led in cycle n+1.
- tick comes PRESCALE-1 cycles after reset release or sync, then every PRESCALE cycles.
- Blink edges are visible 1 cycle after the tick, every (rate+1)*PRESCALE cycles.
- The blink phase relation between channels is fixed by init() after reset or sync. A write realigns only the written channel.
- There is no handshake: every wr_en accepted in a cycle is applied. Back-to-back writes to the same channel are allowed; the last write wins.

## Test plan
The bench uses PRESCALE=4, RATE_W=4, DEFAULT_RATE=1, NUM_LEDS=2 unless stated. Cycle 0 is the first cycle after rst deasserts.
- Reset default:
  - Stimulus: release rst.
  - Required: led=10 in cycle 0; tick in cycles 3, 7, 11, …; led=01 from cycle 8, 10 from cycle 16, alternating every 8 cycles.
- Mode on/off:
  - Stimulus: write ch0 mode=01 in cycle 20, then ch0 mode=00 in cycle 30.
  - Required: led[0]=1 for cycles 21..30 and 0 from cycle 31; led[1] keeps its 8-cycle blink throughout.
- Pulse:
  - Stimulus: write ch1 mode=11, rate=2 in cycle 1.
  - Required: led[1] low until the third tick (cycle 11), high for cycles 12..15, then high for 4 cycles every 12 cycles.
- Write/tick collision and out-of-range write (NUM_LEDS=3):
  - Stimulus: write ch2 blink rate=0 in tick cycle 3; write wr_ch=3 in cycle 5.
  - Required: ch2 ignores tick 3, led[2]=0 in cycle 4, toggles in cycle 8; the wr_ch=3 write changes nothing.
- Sync mid-pattern:
  - Stimulus: pulse sync in cycle 13.
  - Required: led=10 in cycle 14; next tick in cycle 17; first blink toggle in cycle 22.
- Reset mid-operation:
  - Stimulus: assert rst together with wr_en (ch0 on) in cycle 25.
  - Required: the write is ignored; led=10 and pcnt=0 after the edge; the reset-default sequence repeats.
